// File: rtl/riscv_pkg.sv
// riscv_pkg: arbiter FSM states, RV32 load/store funct3 codes and the NOP word
package riscv_pkg;
  typedef enum logic [1:0] {IDLE, IF_ACC, LS_ACC, RESP} state_t;
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte enables, store lane replication, load extraction and misalignment check
module mem_lane_align
  import riscv_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext,
  output logic        mis
);
  logic byte_sz, half_sz;
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    byte_sz = we ? funct3 == SB : (funct3 == LB || funct3 == LBU);
    half_sz = we ? funct3 == SH : (funct3 == LH || funct3 == LHU);
    b = rdata[{addr, 3'b000} +: 8];
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    mis = funct3 == 3'b011 || funct3[2:1] == 2'b11 || (half_sz && addr[0]) ||
          (funct3[1:0] == LW[1:0] && addr != 2'b00);
    be = !we ? 4'hf : byte_sz ? 4'b0001 << addr : half_sz ? (addr[1] ? 4'b1100 : 4'b0011) : 4'hf;
    // replicated store data lets the byte enables pick the lane
    wdata_sh = byte_sz ? {4{wdata[7:0]}} : half_sz ? {2{wdata[15:0]}} : wdata;
    rdata_ext = byte_sz ? {{24{b[7] & ~funct3[2]}}, b} :
                half_sz ? {{16{h[15] & ~funct3[2]}}, h} : rdata;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch and load/store ports arbitrated onto one RAM port.
// Define ARB_RR_EN for round-robin arbitration instead of fixed load/store priority.
module mem_arbiter
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        ls_req,
  input  logic [31:0] ls_addr,
  input  logic [3:0]  ls_mode,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic [31:0] ls_rdata,
  output logic        ls_valid,
  output logic        ls_err,
  output logic        ram_en,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_be,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ready
);
  localparam logic [7:0] TO = 8'(TIMEOUT_CYC);
  state_t state;
  logic [7:0] cnt;
  logic sel_ls, fail, pick_ls, grant, mis;
  logic [31:0] addr_q, wdata_q, rdata_q, wdata_sh, rdata_ext;
  logic [3:0] mode_q, be;
  mem_lane_align u_align (
    .addr(addr_q[1:0]), .funct3(mode_q[3:1]), .we(mode_q[0]), .wdata(wdata_q), .rdata(rdata_q),
    .be(be), .wdata_sh(wdata_sh), .rdata_ext(rdata_ext), .mis(mis)
  );
  // no grant while the previous grant or completion pulse is still visible
  assign grant = state == IDLE && !if_gnt && !ls_gnt && !if_valid && !ls_valid && (if_req || ls_req);
`ifdef ARB_RR_EN
  logic rr;
  assign pick_ls = ls_req && (!if_req || rr);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr <= 1'b1;
    else if (grant) rr <= ~rr;
`else
  assign pick_ls = ls_req;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      sel_ls <= 1'b0;
      fail <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mode_q <= '0;
      if_gnt <= 1'b0;
      if_rdata <= '0;
      if_valid <= 1'b0;
      ls_gnt <= 1'b0;
      ls_rdata <= '0;
      ls_valid <= 1'b0;
      ls_err <= 1'b0;
      ram_en <= 1'b0;
      ram_we <= 1'b0;
      ram_addr <= '0;
      ram_wdata <= '0;
      ram_be <= '0;
    end else begin
      if_gnt <= 1'b0;
      ls_gnt <= 1'b0;
      if_valid <= 1'b0;
      ls_valid <= 1'b0;
      ls_err <= 1'b0;
      case (state)
        IDLE:
          if (ls_gnt && mis) begin
            fail <= 1'b1;
            state <= RESP;
          end else if (if_gnt || ls_gnt) begin
            state <= ls_gnt ? LS_ACC : IF_ACC;
            ram_en <= 1'b1;
            ram_we <= ls_gnt && mode_q[0];
            ram_be <= ls_gnt ? be : 4'hf;
            ram_addr <= {addr_q[31:2], 2'b00};
            ram_wdata <= ls_gnt ? wdata_sh : '0;
          end else if (grant) begin
            ls_gnt <= pick_ls;
            if_gnt <= !pick_ls;
            sel_ls <= pick_ls;
            fail <= 1'b0;
            cnt <= '0;
            addr_q <= pick_ls ? ls_addr : if_addr;
            mode_q <= pick_ls ? ls_mode : {LW, 1'b0};
            wdata_q <= ls_wdata;
          end
        IF_ACC, LS_ACC:
          if (ram_ready) begin
            ram_en <= 1'b0;
            ram_we <= 1'b0;
            rdata_q <= ram_rdata;
            state <= RESP;
          end else if (cnt + 8'd1 == TO) begin
            ram_en <= 1'b0;
            ram_we <= 1'b0;
            fail <= 1'b1;
            state <= RESP;
          end else cnt <= cnt + 8'd1;
        RESP: begin
          state <= IDLE;
          if (sel_ls) begin
            ls_valid <= 1'b1;
            ls_err <= fail;
            ls_rdata <= fail ? '0 : rdata_ext;
          end else begin
            if_valid <= 1'b1;
            if_rdata <= fail ? NOP : rdata_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16, meaning the maximum cycles to wait for ram_ready before aborting (range 1..255).
REQ-002 SHALL have ports, clock and reset first:
  clk  in  1  single clock; all state updates on the rising edge.
  rst_n  in  1  asynchronous, active-low reset.
  if_req  in  1  instruction-fetch request, held until if_valid.
  if_addr  in  32  fetch address, word aligned.
  if_gnt  out  1  one-cycle pulse when the fetch is accepted.
  if_rdata  out  32  fetched word, valid with if_valid.
  if_valid  out  1  one-cycle fetch completion pulse.
  ls_req  in  1  load/store request, held until ls_valid.
  ls_addr  in  32  byte address.
  ls_mode  in  4  {funct3, we}; we=1 is a store.
  ls_wdata  in  32  store data, right-aligned.
  ls_gnt  out  1  one-cycle pulse when the load/store is accepted.
  ls_rdata  out  32  load result, sign- or zero-extended.
  ls_valid  out  1  one-cycle load/store completion pulse.
  ls_err  out  1  qualifies ls_valid: misaligned access or timeout.
  ram_en, ram_we  out  1  RAM access strobe and write enable.
  ram_addr  out  32  word address (byte address with [1:0] cleared).
  ram_wdata  out  32  lane-shifted store data.
  ram_be  out  4  byte enables.
  ram_rdata  in  32  RAM read data, valid with ram_ready.
  ram_ready  in  1  RAM completion, sampled while ram_en=1.

Function
REQ-003 SHALL implement the FSM states IDLE, IF_ACC, LS_ACC and RESP.
REQ-004 SHALL, in IDLE, grant exactly one pending requester per cycle, pulse its gnt, latch its address, mode and data, and move to IF_ACC or LS_ACC on the next edge.
REQ-005 SHALL, when both requests are pending in IDLE, grant ls (fixed priority) unless ARB_RR_EN is defined.
REQ-006 SHALL, in IF_ACC and LS_ACC, hold ram_en=1 with stable ram_* outputs until ram_ready=1, then register the read data and go to RESP.
REQ-007 SHALL, in RESP, pulse the granted requester's valid for exactly one cycle and return to IDLE; a new grant is possible no earlier than the cycle after RESP.
REQ-008 SHALL give a minimum latency of 3 cycles from gnt to valid when ram_ready is returned in the first access cycle.
REQ-009 SHALL set ram_be for SB to one lane selected by addr[1:0], for SH to 0011 or 1100 selected by addr[1], and for SW to 1111; loads SHALL use ram_be=1111 and ram_we=0.
REQ-010 SHALL extract loads by lane: LB and LH sign-extended, LBU and LHU zero-extended, LW unchanged.
REQ-011 SHALL treat halfword accesses with addr[0]=1, word accesses with addr[1:0]!=0, and funct3 values 011, 110 or 111 as errors: no RAM access, go directly to RESP, ls_valid=1, ls_err=1, ls_rdata=0.
REQ-012 SHALL count wait cycles in the access states; when the count reaches TIMEOUT_CYC without ram_ready, it SHALL drop ram_en and go to RESP with ls_err=1 for ls, or with if_rdata=32'h00000013 (NOP) for if.
REQ-013 SHALL ignore ram_ready outside the access states.

Reset
REQ-014 SHALL, while rst_n=0, force state IDLE, wait counter 0, round-robin pointer to ls, and drive all outputs to 0.
REQ-015 SHALL, when reset asserts mid-access, abandon the transaction without emitting a valid pulse.

Configuration
REQ-016 SHALL, with ARB_RR_EN defined, grant simultaneous requests round-robin, with the pointer toggling after every grant; without ARB_RR_EN it SHALL use fixed ls priority and contain no pointer flop.

Structure
REQ-017 SHALL place the FSM state enum, the funct3 load/store codes (LB, LH, LW, LBU, LHU, SB, SH, SW) and the NOP constant in the shared package riscv_pkg.
REQ-018 SHALL implement the combinational lane logic (byte enables, store shift, load extract, misalignment check) in a sub-module mem_lane_align.

Verification
REQ-019 SHALL cover: if_req only, addr 0x100, ram_ready in the first access cycle -> if_valid 3 cycles after if_gnt, with if_rdata equal to ram_rdata.
REQ-020 SHALL cover: LB at 0x203 with ram_rdata=0x80FF_FF_FF -> ls_rdata=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-021 SHALL cover: SH at 0x102 with ls_wdata=0x0000BEEF -> ram_be=1100, ram_wdata[31:16]=0xBEEF, ram_addr=0x100.
REQ-022 SHALL cover: SW at 0x101 -> ram_en never asserts, ls_valid=1 with ls_err=1 two cycles after ls_gnt.
REQ-023 SHALL cover: if_req and ls_req held together for 4 transactions -> grant order ls,ls,ls,ls without ARB_RR_EN, and ls,if,ls,if with it.
REQ-024 SHALL cover: ram_ready held at 0 -> timeout after 16 cycles, if_rdata=0x00000013; and rst_n pulsed mid-access -> no valid pulse, and all outputs are 0.
